// File: rtl/shift_unit_pkg.sv
// shift_unit_pkg: op encodings and fill-bit helper for the pipelined barrel shifter
package shift_unit_pkg;
  typedef logic [1:0] shift_op_t;
  localparam shift_op_t OP_SRL = 2'b00;
  localparam shift_op_t OP_SLL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b10;
  localparam shift_op_t OP_ROR = 2'b11;
  // Earlier SRA stages never change the MSB, so the current MSB is still the original sign bit.
  function automatic logic fill_bit(input shift_op_t op, input logic msb);
    return op == OP_SRA && msb;
  endfunction
endpackage

// File: rtl/shift_unit_stage.sv
// shift_unit_stage: one registered mux stage shifting by STEP when its shamt bit is set
// Optional rotate-right for op 2'b11 under SHIFT_UNIT_ROTATE_EN.
module shift_unit_stage
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic [1:0]       out_op,
  input  logic             dn_adv,
  output logic             up_adv
);
  localparam int IDX = $clog2(STEP);
  logic fill;
  logic [WIDTH-1:0] shifted;
  assign fill = fill_bit(in_op, in_data[WIDTH-1]);
`ifdef SHIFT_UNIT_ROTATE_EN
  assign shifted = in_op == OP_SLL ? {in_data[WIDTH-STEP-1:0], {STEP{1'b0}}}
                 : in_op == OP_ROR ? {in_data[STEP-1:0], in_data[WIDTH-1:STEP]}
                 : {{STEP{fill}}, in_data[WIDTH-1:STEP]};
`else
  assign shifted = in_op == OP_SLL ? {in_data[WIDTH-STEP-1:0], {STEP{1'b0}}}
                 : {{STEP{fill}}, in_data[WIDTH-1:STEP]};
`endif
  assign up_adv = !out_valid || dn_adv;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_op    <= '0;
    end else if (up_adv) begin
      out_valid <= in_valid;
      out_data  <= in_shamt[IDX] ? shifted : in_data;
      out_shamt <= in_shamt;
      out_op    <= in_op;
    end
  end
endmodule

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: SHW-stage pipelined SRL/SLL/SRA barrel shifter with valid/ready flow control
// Define SHIFT_UNIT_ROTATE_EN to turn op 2'b11 into ROR; otherwise it behaves as SRL.
module shift_unit_pipe
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  logic [SHW:0] v, adv;
  logic [SHW:0][WIDTH-1:0] d;
  logic [SHW:0][SHW-1:0] sh;
  logic [SHW:0][1:0] op;
  logic unused_tail;
  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign sh[0] = in_shamt;
  assign op[0] = in_op;
  assign adv[SHW] = out_ready;
  assign in_ready = adv[0];
  assign out_valid = v[SHW];
  assign out_data = d[SHW];
  assign out_zero = ~|d[SHW];
  assign unused_tail = ^{sh[SHW], op[SHW]};
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    shift_unit_stage #(.WIDTH(WIDTH), .STEP(1 << i), .SHW(SHW)) u_stage (
      .clk(clk), .reset(reset),
      .in_valid(v[i]), .in_data(d[i]), .in_shamt(sh[i]), .in_op(op[i]),
      .out_valid(v[i+1]), .out_data(d[i+1]), .out_shamt(sh[i+1]), .out_op(op[i+1]),
      .dn_adv(adv[i+1]), .up_adv(adv[i])
    );
  end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: directed vector table plus stall, random-stream and reset sequences
module tb_shift_unit_pipe;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_zero;
  logic [31:0] in_data = 0, out_data;
  logic [4:0] in_shamt = 0;
  logic [1:0] in_op = 0;
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] d; logic [4:0] s; logic [1:0] op; logic [31:0] exp;} vec_t;
  vec_t vt[14];
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [31:0] ROR_EXP = 32'h8000_0000;
`else
  localparam logic [31:0] ROR_EXP = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  shift_unit_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    case (op)
      2'b00: return d >> s;
      2'b01: return d << s;
      2'b10: return 32'($signed(d) >>> s);
`ifdef SHIFT_UNIT_ROTATE_EN
      default: return (d >> s) | (d << (6'd32 - {1'b0, s}));
`else
      default: return d >> s;
`endif
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, sent, recv, first_block, stab_err, cnt;
    logic [31:0] held, q[$];
    logic stalled;
    logic [31:0] cd;
    logic [4:0] cs;
    logic [1:0] co;
    vt[0]  = '{32'h8000_0000, 5'd31, 2'b00, 32'h0000_0001};
    vt[1]  = '{32'h0000_0001, 5'd31, 2'b01, 32'h8000_0000};
    vt[2]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000};
    vt[3]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
    vt[4]  = '{32'hFFFF_FFFF, 5'd17, 2'b10, 32'hFFFF_FFFF};
    vt[5]  = '{32'hA5A5_A5A5, 5'd0,  2'b00, 32'hA5A5_A5A5};
    vt[6]  = '{32'hA5A5_A5A5, 5'd0,  2'b01, 32'hA5A5_A5A5};
    vt[7]  = '{32'hA5A5_A5A5, 5'd0,  2'b10, 32'hA5A5_A5A5};
    vt[8]  = '{32'hA5A5_A5A5, 5'd0,  2'b11, 32'hA5A5_A5A5};
    vt[9]  = '{32'h0000_0001, 5'd1,  2'b11, ROR_EXP};
    vt[10] = '{32'hF000_0000, 5'd8,  2'b00, 32'h00F0_0000};
    vt[11] = '{32'h1234_5678, 5'd4,  2'b01, 32'h2345_6780};
    vt[12] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
    vt[13] = '{32'h9000_0000, 5'd1,  2'b10, 32'hC800_0000};

    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", out_data, 0);
    check("reset out_zero", 32'(out_zero), 1);
    check("reset in_ready", 32'(in_ready), 1);

    foreach (vt[k]) begin
      @(negedge clk);
      in_valid = 1; in_data = vt[k].d; in_shamt = vt[k].s; in_op = vt[k].op;
      @(negedge clk);
      in_valid = 0; lat = 1;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d latency", k), 32'(lat), 5);
      check($sformatf("vec%0d data", k), out_data, vt[k].exp);
      check($sformatf("vec%0d zero", k), 32'(out_zero), 32'(vt[k].exp == 0));
    end

    // Stall: fill the pipe, hold the consumer, then drain in order.
    @(negedge clk);
    sent = 0; recv = 0; first_block = -1; stab_err = 0; stalled = 0; held = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      out_ready = (cyc < 2) || (cyc >= 16);
      in_valid = sent < 8; in_data = 32'(sent + 1); in_shamt = 0; in_op = 2'b00;
      #1;
      if (stalled && out_data !== held) stab_err++;
      if (in_valid && !in_ready && first_block < 0) first_block = sent;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        recv++;
        check($sformatf("stall order %0d", recv), out_data, 32'(recv));
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    check("stall block point", 32'(first_block), 5);
    check("stall stability", 32'(stab_err), 0);
    check("stall count", 32'(recv), 8);

    // Random stream with random back-pressure against the reference model.
    sent = 0; recv = 0;
    cd = $urandom; cs = 5'($urandom); co = 2'($urandom);
    for (int cyc = 0; cyc < 2000 && recv < 40; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = sent < 40 && ($urandom_range(0, 4) != 0);
      in_data = cd; in_shamt = cs; in_op = co;
      #1;
      if (out_valid && out_ready) begin
        recv++;
        if (q.size() == 0) check("rand spurious", out_data, 32'hxxxx_xxxx);
        else check($sformatf("rand %0d", recv), out_data, q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(cd, cs, co));
        sent++;
        cd = $urandom; cs = 5'($urandom); co = 2'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    check("rand count", 32'(recv), 40);
    check("rand leftover", 32'(q.size()), 0);

    // Reset with three operations in flight.
    repeat (6) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = 32'hFFFF_0000 + 32'(k); in_shamt = 5'(k); in_op = 2'b01;
      @(negedge clk);
    end
    reset = 1; in_data = 32'h1234_5678;
    @(negedge clk);
    reset = 0; in_valid = 0;
    #1;
    check("midreset out_valid", 32'(out_valid), 0);
    check("midreset out_data", out_data, 0);
    check("midreset out_zero", 32'(out_zero), 1);
    check("midreset in_ready", 32'(in_ready), 1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check("midreset no stale output", 32'(cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
